// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rtc_pkg
// Brief    : Shared constants for the RTC multiplexed-bus sequencer: state
//            encoding, phase timing default and a state classification helper.
// Revision : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    // Default number of clk cycles spent in each bus phase
    localparam int unsigned c_T_PHASE_DEFAULT = 10;

    // Width of the phase timer
    localparam int unsigned c_CNT_W = 8;

    // FSM state encoding
    localparam int unsigned c_STATE_W = 3;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE     = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_A_SETUP  = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_A_STROBE = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_A_HOLD   = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_D_SETUP  = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_D_STROBE = 3'd5;
    localparam logic [c_STATE_W-1:0] c_ST_D_HOLD   = 3'd6;
    localparam logic [c_STATE_W-1:0] c_ST_DONE     = 3'd7;

    // True for the six timed bus-phase states (A_SETUP .. D_HOLD)
    function automatic logic is_phase_state(input logic [c_STATE_W-1:0] st);
        return (st != c_ST_IDLE) && (st != c_ST_DONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_bus_sequencer_phase_counter.sv
`default_nettype none
// ============================================================================
// Module   : phase_counter
// Brief    : Loadable down-counter timing one bus phase. Loading N makes
//            expire_o rise N cycles later; the count saturates at zero so it
//            never wraps inside a phase.
// Revision : 1.0 - initial release
// ============================================================================
module phase_counter
    import rtc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [c_CNT_W-1:0] load_val_i,
    output logic               expire_o
);

    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] count_d;

    // Reload on request, otherwise count down and hold at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rtc_bus_sequencer
// Brief    : Sequences one read or write on a multiplexed address/data RTC
//            bus: address phase (setup/strobe/hold), data phase
//            (setup/strobe/hold), then a one-cycle DONE. All outputs are
//            registered and computed from the next state, so they line up
//            with the state they belong to.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_bus_sequencer
    import rtc_pkg::*;
#(
    parameter int unsigned T_PHASE = c_T_PHASE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       write_en,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic [7:0] rtc_ad_out,
    output logic       rtc_ad_oe,
    input  logic [7:0] rtc_ad_in,
    output logic       rtc_cs_n,
    output logic       rtc_ad_n,
    output logic       rtc_wr_n,
    output logic       rtc_rd_n,
    output logic       w_r
);

    localparam logic [c_CNT_W-1:0] c_PHASE_LOAD = c_CNT_W'(T_PHASE - 1);

    logic [c_STATE_W-1:0] state_q, state_d;
    logic                 we_q, we_d;
    logic [7:0]           addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [7:0]           rdata_q, rdata_d;

    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [7:0]           ad_out_q, ad_out_d;
    logic                 oe_q, oe_d;
    logic                 cs_n_q, cs_n_d;
    logic                 ad_n_q, ad_n_d;
    logic                 wr_n_q, wr_n_d;
    logic                 rd_n_q, rd_n_d;

    logic                 w_expire;
    logic                 w_load;
    logic [c_CNT_W-1:0]   w_load_val;

    // Timer restarts on every state change; only timed phases get a length
    assign w_load     = (state_d != state_q);
    assign w_load_val = is_phase_state(state_d) ? c_PHASE_LOAD : '0;

    phase_counter u_phase_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_load),
        .load_val_i (w_load_val),
        .expire_o   (w_expire)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE waits for start, timed phases advance on expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:     if (start)    state_d = c_ST_A_SETUP;
            c_ST_A_SETUP:  if (w_expire) state_d = c_ST_A_STROBE;
            c_ST_A_STROBE: if (w_expire) state_d = c_ST_A_HOLD;
            c_ST_A_HOLD:   if (w_expire) state_d = c_ST_D_SETUP;
            c_ST_D_SETUP:  if (w_expire) state_d = c_ST_D_STROBE;
            c_ST_D_STROBE: if (w_expire) state_d = c_ST_D_HOLD;
            c_ST_D_HOLD:   if (w_expire) state_d = c_ST_DONE;
            default:                     state_d = c_ST_IDLE;
        endcase
    end

    // Request latches load only when a transaction is accepted; read data is
    // captured on the last D_STROBE cycle of a read
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if ((state_q == c_ST_IDLE) && start) begin
            we_d    = write_en;
            addr_d  = addr;
            wdata_d = wdata;
        end
        if ((state_q == c_ST_D_STROBE) && w_expire && !we_q) begin
            rdata_d = rtc_ad_in;
        end
    end

    // Output decode from the next state so registered outputs match it
    always_comb begin
        busy_d   = (state_d != c_ST_IDLE);
        done_d   = (state_d == c_ST_DONE);
        cs_n_d   = 1'b1;
        ad_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        oe_d     = 1'b0;
        ad_out_d = 8'h00;
        case (state_d)
            c_ST_A_SETUP, c_ST_A_STROBE, c_ST_A_HOLD: begin
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                oe_d     = 1'b1;
                ad_out_d = addr_d;
                wr_n_d   = (state_d != c_ST_A_STROBE);
            end
            c_ST_D_SETUP, c_ST_D_STROBE, c_ST_D_HOLD: begin
                cs_n_d = 1'b0;
                if (we_d) begin
                    oe_d     = 1'b1;
                    ad_out_d = wdata_d;
                    wr_n_d   = (state_d != c_ST_D_STROBE);
                end else begin
                    rd_n_d   = (state_d != c_ST_D_STROBE);
                end
            end
            default: ;
        endcase
    end

    // Latches and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q     <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            ad_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            oe_q     <= 1'b0;
            ad_out_q <= 8'h00;
        end else begin
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cs_n_q   <= cs_n_d;
            ad_n_q   <= ad_n_d;
            wr_n_q   <= wr_n_d;
            rd_n_q   <= rd_n_d;
            oe_q     <= oe_d;
            ad_out_q <= ad_out_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign rtc_ad_out = ad_out_q;
    assign rtc_ad_oe  = oe_q;
    assign rtc_cs_n   = cs_n_q;
    assign rtc_ad_n   = ad_n_q;
    assign rtc_wr_n   = wr_n_q;
    assign rtc_rd_n   = rd_n_q;
    assign w_r        = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_bus_sequencer
// Brief    : Self-checking bench for rtc_bus_sequencer with T_PHASE=2.
//            Cycle c of a transaction is the cycle after clock edge c-1,
//            start being sampled at edge 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_sequencer;

    localparam int TP = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       write_en = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rtc_ad_in = 8'h3C;
    logic       busy, done, rtc_ad_oe, rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n, w_r;
    logic [7:0] rdata, rtc_ad_out;
    logic [15:0] dut_vec;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rin;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        int         cyc;
    } sb_t;

    sb_t        sb_q[$];
    vec_t       vecs[6];
    logic [7:0] exp_rdata;
    int         n_pass = 0;
    int         n_total = 0;

    rtc_bus_sequencer #(.T_PHASE(TP)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .write_en   (write_en),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .rtc_ad_out (rtc_ad_out),
        .rtc_ad_oe  (rtc_ad_oe),
        .rtc_ad_in  (rtc_ad_in),
        .rtc_cs_n   (rtc_cs_n),
        .rtc_ad_n   (rtc_ad_n),
        .rtc_wr_n   (rtc_wr_n),
        .rtc_rd_n   (rtc_rd_n),
        .w_r        (w_r)
    );

    always #5 clk = ~clk;

    assign dut_vec = {busy, done, rtc_cs_n, rtc_ad_n, rtc_wr_n, rtc_rd_n,
                      rtc_ad_oe, w_r, rtc_ad_out};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected bus vector for cycle c of a transaction (c<=0 or beyond: idle)
    function automatic logic [15:0] exp_bus(input int c, input logic we,
                                            input logic [7:0] a, input logic [7:0] d);
        logic       b, dn, cs, adn, wrn, rdn, oe;
        logic [7:0] o;
        int         p;
        b = 0; dn = 0; cs = 1; adn = 1; wrn = 1; rdn = 1; oe = 0; o = 8'h00;
        if (c >= 1 && c <= 6*TP) begin
            p  = (c - 1) / TP;
            b  = 1;
            cs = 0;
            if (p < 3) begin
                adn = 0; oe = 1; o = a; wrn = (p != 1);
            end else if (we) begin
                oe = 1; o = d; wrn = (p != 4);
            end else begin
                rdn = (p != 4);
            end
        end else if (c == 6*TP + 1) begin
            b = 1; dn = 1;
        end
        return {b, dn, cs, adn, wrn, rdn, oe, oe, o};
    endfunction

    // One transaction; glitch_c re-pulses start in that cycle, abort_c asserts
    // reset in that cycle (0 disables either)
    task automatic run_txn(input vec_t v, input int glitch_c, input int abort_c);
        sb_t e;
        write_en  = v.we;
        addr      = v.addr;
        wdata     = v.wdata;
        start     = 1'b1;
        reset     = 1'b0;
        rtc_ad_in = 8'h3C;
        if (abort_c == 0) begin
            e.rdata = v.we ? exp_rdata : v.rin;
            e.cyc   = 6*TP + 1;
            sb_q.push_back(e);
        end
        for (int c = 1; c <= 6*TP + 2; c++) begin
            @(posedge clk); #1;
            if (abort_c != 0 && c > abort_c) begin
                chk("bus_abort", dut_vec, exp_bus(0, v.we, v.addr, v.wdata));
                exp_rdata = 8'h00;
            end else begin
                chk("bus", dut_vec, exp_bus(c, v.we, v.addr, v.wdata));
                if (!v.we && c == 5*TP + 1) exp_rdata = v.rin;
            end
            chk("rdata", rdata, exp_rdata);
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_rdata", rdata, e.rdata);
                    chk("sb_latency", c, e.cyc);
                end
            end
            start     = (c == glitch_c);
            write_en  = ~v.we;
            addr      = ~v.addr;
            wdata     = ~v.wdata;
            reset     = (c == abort_c);
            rtc_ad_in = (c == 5*TP) ? v.rin : 8'h3C;
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{we: 1'b1, addr: 8'h12, wdata: 8'h59, rin: 8'h00};
        vecs[1] = '{we: 1'b0, addr: 8'h05, wdata: 8'h00, rin: 8'hA7};
        vecs[2] = '{we: 1'b1, addr: 8'hFF, wdata: 8'h00, rin: 8'h11};
        vecs[3] = '{we: 1'b0, addr: 8'h80, wdata: 8'hC3, rin: 8'h5A};
        vecs[4] = '{we: 1'b0, addr: 8'h00, wdata: 8'h00, rin: 8'hFF};
        vecs[5] = '{we: 1'b1, addr: 8'h00, wdata: 8'hFF, rin: 8'h00};
        exp_rdata = 8'h00;

        // Reset state, while held and after release
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bus", dut_vec, exp_bus(0, 1'b0, 8'h00, 8'h00));
        chk("reset_rdata", rdata, 8'h00);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_bus", dut_vec, exp_bus(0, 1'b0, 8'h00, 8'h00));

        // Reset in cycle 8 of a write: no done, rdata stays 0
        run_txn(vecs[0], 0, 8);

        // Table of plain transactions
        for (int i = 0; i < 6; i++) run_txn(vecs[i], 0, 0);

        // Start re-pulsed mid-transaction and again in the DONE cycle
        v = '{we: 1'b1, addr: 8'h2B, wdata: 8'h96, rin: 8'h00};
        run_txn(v, 5, 0);
        v = '{we: 1'b0, addr: 8'h44, wdata: 8'h00, rin: 8'hC9};
        run_txn(v, 13, 0);

        // Reset on the capture edge of a read: no capture, rdata cleared
        v = '{we: 1'b0, addr: 8'h07, wdata: 8'h00, rin: 8'h3E};
        run_txn(v, 0, 10);

        // Back-to-back with start held high
        write_en  = 1'b0;
        addr      = 8'h33;
        wdata     = 8'h00;
        rtc_ad_in = 8'h6E;
        start     = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            chk("b2b_done", done, (c == 13 || c == 27));
            chk("b2b_busy", busy, !(c == 14 || c >= 28));
            chk("b2b_overlap", (!rtc_rd_n && !rtc_wr_n), 1'b0);
            if (c == 27) start = 1'b0;
        end
        chk("b2b_rdata", rdata, 8'h6E);

        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
